// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM bus arbiter.
package sram_arb_pkg;

    localparam int unsigned AW_DEFAULT = 10;
    localparam int unsigned DW_DEFAULT = 4;

    typedef enum logic [2:0] {
        StIdle,
        StVid,
        StCpuRd,
        StCpuWs,
        StCpuWp,
        StCpuWh
    } arb_state_t;

endpackage

// File: rtl/sram_bus_arbiter.sv
// Video/CPU arbiter and pin sequencer for an async 1024x4 SRAM bank.
// SRAM_ARB_OVERRUN_EN enables the sticky video overrun flag.
module sram_bus_arbiter #(
    parameter int unsigned AW = sram_arb_pkg::AW_DEFAULT,
    parameter int unsigned DW = sram_arb_pkg::DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic [DW-1:0] o_cpu_rdata,
    output logic          o_cpu_ack,
    input  logic          i_vid_req,
    input  logic [AW-1:0] i_vid_addr,
    output logic [DW-1:0] o_vid_data,
    output logic          o_vid_valid,
    output logic          o_vid_overrun,
    output logic [AW-1:0] o_ram_a,
    output logic          o_ram_cs_n,
    output logic          o_ram_we_n,
    output logic [DW-1:0] o_ram_d_out,
    output logic          o_ram_d_oe,
    input  logic [DW-1:0] i_ram_d_in
);
    import sram_arb_pkg::*;

    arb_state_t    r_state;
    arb_state_t    w_state_d;
    logic          w_vid_now;
    logic          w_cpu_now;
    logic          w_enter_vid;
    logic [AW-1:0] w_vid_addr;

    logic          r_vid_pend;
    logic [AW-1:0] r_vid_paddr;
    logic [AW-1:0] r_ram_a;
    logic [DW-1:0] r_ram_d_out;
    logic          r_cs_n;
    logic          r_we_n;
    logic          r_oe;
    logic [DW-1:0] r_cpu_rdata;
    logic          r_cpu_ack;
    logic [DW-1:0] r_vid_data;
    logic          r_vid_valid;
`ifdef SRAM_ARB_OVERRUN_EN
    logic          r_overrun;
`endif

    // A fresh strobe always wins over (and replaces) a pending address.
    assign w_vid_now   = i_vid_req | r_vid_pend;
    assign w_cpu_now   = i_cpu_req & ~r_cpu_ack;
    assign w_vid_addr  = i_vid_req ? i_vid_addr : r_vid_paddr;
    assign w_enter_vid = (w_state_d == StVid);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle, StVid: begin
                if (w_vid_now) begin
                    w_state_d = StVid;
                end else if (w_cpu_now) begin
                    w_state_d = i_cpu_we ? StCpuWs : StCpuRd;
                end else begin
                    w_state_d = StIdle;
                end
            end
            StCpuRd, StCpuWh: w_state_d = w_vid_now ? StVid : StIdle;
            StCpuWs:          w_state_d = StCpuWp;
            StCpuWp:          w_state_d = StCpuWh;
            default:          w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_vid_pend  <= 1'b0;
            r_vid_paddr <= '0;
            r_ram_a     <= '0;
            r_ram_d_out <= '0;
            r_cs_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_oe        <= 1'b0;
            r_cpu_rdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_vid_data  <= '0;
            r_vid_valid <= 1'b0;
`ifdef SRAM_ARB_OVERRUN_EN
            r_overrun   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;

            if (w_enter_vid) begin
                r_vid_pend <= 1'b0;
            end else if (i_vid_req) begin
                r_vid_pend  <= 1'b1;
                r_vid_paddr <= i_vid_addr;
            end
`ifdef SRAM_ARB_OVERRUN_EN
            if (i_vid_req && r_vid_pend) begin
                r_overrun <= 1'b1;
            end
`endif

            // Address/data are captured only when an access starts, then held.
            if (w_enter_vid) begin
                r_ram_a <= w_vid_addr;
            end else if (w_state_d == StCpuRd) begin
                r_ram_a <= i_cpu_addr;
            end else if (w_state_d == StCpuWs && r_state != StCpuWs) begin
                r_ram_a     <= i_cpu_addr;
                r_ram_d_out <= i_cpu_wdata;
            end

            unique case (w_state_d)
                StVid, StCpuRd: begin
                    r_cs_n <= 1'b0;
                    r_we_n <= 1'b1;
                    r_oe   <= 1'b0;
                end
                StCpuWs, StCpuWh: begin
                    r_cs_n <= 1'b1;
                    r_we_n <= 1'b1;
                    r_oe   <= 1'b1;
                end
                StCpuWp: begin
                    r_cs_n <= 1'b0;
                    r_we_n <= 1'b0;
                    r_oe   <= 1'b1;
                end
                default: begin
                    r_cs_n <= 1'b1;
                    r_we_n <= 1'b1;
                    r_oe   <= 1'b0;
                end
            endcase

            r_vid_valid <= (r_state == StVid);
            if (r_state == StVid) begin
                r_vid_data <= i_ram_d_in;
            end
            r_cpu_ack <= (r_state == StCpuRd) || (r_state == StCpuWh);
            if (r_state == StCpuRd) begin
                r_cpu_rdata <= i_ram_d_in;
            end
        end
    end

    assign o_ram_a     = r_ram_a;
    assign o_ram_cs_n  = r_cs_n;
    assign o_ram_we_n  = r_we_n;
    assign o_ram_d_out = r_ram_d_out;
    assign o_ram_d_oe  = r_oe;
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_cpu_ack   = r_cpu_ack;
    assign o_vid_data  = r_vid_data;
    assign o_vid_valid = r_vid_valid;
`ifdef SRAM_ARB_OVERRUN_EN
    assign o_vid_overrun = r_overrun;
`else
    assign o_vid_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with an SRAM model and a scoreboard checker.
`timescale 1ns/1ps
module tb_sram_bus_arbiter;
    localparam int AW = 10;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_cpu_req = 1'b0;
    logic          i_cpu_we = 1'b0;
    logic [AW-1:0] i_cpu_addr = '0;
    logic [DW-1:0] i_cpu_wdata = '0;
    logic          i_vid_req = 1'b0;
    logic [AW-1:0] i_vid_addr = '0;
    logic [DW-1:0] o_cpu_rdata, o_vid_data, o_ram_d_out, w_ram_d_in;
    logic          o_cpu_ack, o_vid_valid, o_vid_overrun;
    logic          o_ram_cs_n, o_ram_we_n, o_ram_d_oe;
    logic [AW-1:0] o_ram_a;

    logic [DW-1:0] mem  [1024];
    logic [DW-1:0] gmem [1024];

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;

    logic          cur_we = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;
    logic [AW-1:0] exp_vid_addr = '0;
    int            vid_cnt = 0;
    int            last_vid_cyc = 0;
    logic [DW-1:0] last_vid_data = '0;
    int            wen_low_cnt = 0;

`ifdef SRAM_ARB_OVERRUN_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    sram_bus_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cpu_req    (i_cpu_req),
        .i_cpu_we     (i_cpu_we),
        .i_cpu_addr   (i_cpu_addr),
        .i_cpu_wdata  (i_cpu_wdata),
        .o_cpu_rdata  (o_cpu_rdata),
        .o_cpu_ack    (o_cpu_ack),
        .i_vid_req    (i_vid_req),
        .i_vid_addr   (i_vid_addr),
        .o_vid_data   (o_vid_data),
        .o_vid_valid  (o_vid_valid),
        .o_vid_overrun(o_vid_overrun),
        .o_ram_a      (o_ram_a),
        .o_ram_cs_n   (o_ram_cs_n),
        .o_ram_we_n   (o_ram_we_n),
        .o_ram_d_out  (o_ram_d_out),
        .o_ram_d_oe   (o_ram_d_oe),
        .i_ram_d_in   (w_ram_d_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Async SRAM: reads while selected and not writing, writes during the we_n low pulse.
    assign w_ram_d_in = (!o_ram_cs_n && o_ram_we_n) ? mem[o_ram_a] : '0;
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 4'(i ^ 5);
        forever begin
            @(negedge clk);
            if (rst_n && !o_ram_cs_n && !o_ram_we_n && o_ram_d_oe) mem[o_ram_a] = o_ram_d_out;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Scoreboard: golden memory updated on write completion; every ack/valid is checked.
    initial begin
        logic          prev_we_n;
        logic [AW-1:0] prev_a;
        prev_we_n = 1'b1;
        prev_a = '0;
        for (int i = 0; i < 1024; i++) gmem[i] = 4'(i ^ 5);
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("no_contention", {31'b0, o_ram_d_oe & ~o_ram_cs_n & o_ram_we_n}, 32'd0);
                if (!o_ram_we_n) begin
                    wen_low_cnt++;
                    chk("we_pulse_start", {31'b0, prev_we_n}, 32'd1);
                    chk("wp_addr_held", {22'b0, o_ram_a}, {22'b0, prev_a});
                    chk("wp_addr", {22'b0, o_ram_a}, {22'b0, cur_addr});
                    chk("wp_data", {28'b0, o_ram_d_out}, {28'b0, cur_wdata});
                end
                if (!prev_we_n) chk("wh_addr_held", {22'b0, o_ram_a}, {22'b0, prev_a});
                if (o_cpu_ack) begin
                    if (cur_we) gmem[cur_addr] = cur_wdata;
                    else chk("cpu_rdata_model", {28'b0, o_cpu_rdata}, {28'b0, gmem[cur_addr]});
                end
                if (o_vid_valid) begin
                    vid_cnt++;
                    last_vid_cyc = cyc;
                    last_vid_data = o_vid_data;
                    chk("vid_data_model", {28'b0, o_vid_data}, {28'b0, gmem[exp_vid_addr]});
                end
            end
            prev_we_n = o_ram_we_n;
            prev_a = o_ram_a;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // CPU access with up to two video strobes driven at loop steps v1/v2 (step 0 = edge k).
    task automatic cpu_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int v1, input logic [AW-1:0] va1,
                          input int v2, input logic [AW-1:0] va2,
                          output int lat, output int vk);
        int   k;
        logic done;
        k = 0;
        lat = -1;
        vk = -1;
        done = 1'b0;
        cur_we = we;
        cur_addr = addr;
        cur_wdata = wd;
        i_cpu_we = we;
        i_cpu_addr = addr;
        i_cpu_wdata = wd;
        i_cpu_req = 1'b1;
        for (int s = 0; s < 20 && !done; s++) begin
            i_vid_req = 1'b0;
            if (s == v1) begin
                i_vid_req = 1'b1;
                i_vid_addr = va1;
                exp_vid_addr = va1;
            end
            if (s == v2) begin
                i_vid_req = 1'b1;
                i_vid_addr = va2;
                exp_vid_addr = va2;
            end
            step();
            if (i_vid_req) vk = cyc;
            i_vid_req = 1'b0;
            if (s == 0) k = cyc;
            if (o_cpu_ack) begin
                lat = cyc - k;
                i_cpu_req = 1'b0;
                done = 1'b1;
            end
        end
        i_cpu_req = 1'b0;
        i_vid_req = 1'b0;
        if (!done) chk("cpu_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic vid_wait(input int n0, input int vk, output int lat);
        lat = -1;
        for (int s = 0; s < 10 && lat < 0; s++) begin
            if (vid_cnt != n0) lat = last_vid_cyc - vk;
            else step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, vk, n0, w0;

        // Reset state
        step();
        step();
        chk("rst_cs_n", {31'b0, o_ram_cs_n}, 32'd1);
        chk("rst_we_n", {31'b0, o_ram_we_n}, 32'd1);
        chk("rst_oe", {31'b0, o_ram_d_oe}, 32'd0);
        chk("rst_ram_a", {22'b0, o_ram_a}, 32'd0);
        chk("rst_d_out", {28'b0, o_ram_d_out}, 32'd0);
        chk("rst_rdata", {28'b0, o_cpu_rdata}, 32'd0);
        chk("rst_vid_data", {28'b0, o_vid_data}, 32'd0);
        chk("rst_ack_valid", {30'b0, o_cpu_ack, o_vid_valid}, 32'd0);
        chk("rst_overrun", {31'b0, o_vid_overrun}, 32'd0);
        rst_n = 1'b1;
        step();

        // Write 0xB to 0x3A5, then read it back
        w0 = wen_low_cnt;
        cpu_op(1'b1, 10'h3A5, 4'hB, -1, '0, -1, '0, lat, vk);
        chk("wr_lat", lat, 32'd3);
        step();
        chk("we_pulse_count", wen_low_cnt - w0, 32'd1);
        cpu_op(1'b0, 10'h3A5, 4'h0, -1, '0, -1, '0, lat, vk);
        chk("rd_lat", lat, 32'd1);
        chk("rd_data", {28'b0, o_cpu_rdata}, 32'hB);
        step();

        // Preload 0x010 = 0x6, then video fetch from idle
        cpu_op(1'b1, 10'h010, 4'h6, -1, '0, -1, '0, lat, vk);
        step();
        step();
        n0 = vid_cnt;
        exp_vid_addr = 10'h010;
        i_vid_addr = 10'h010;
        i_vid_req = 1'b1;
        step();
        vk = cyc;
        i_vid_req = 1'b0;
        vid_wait(n0, vk, lat);
        chk("vid_lat", lat, 32'd1);
        chk("vid_data", {28'b0, last_vid_data}, 32'h6);
        step();

        // Video and CPU read in the same cycle: video first
        n0 = vid_cnt;
        cpu_op(1'b0, 10'h3A5, 4'h0, 0, 10'h010, -1, '0, lat, vk);
        chk("both_cpu_lat", lat, 32'd2);
        chk("both_cpu_data", {28'b0, o_cpu_rdata}, 32'hB);
        vid_wait(n0, vk, lat);
        chk("both_vid_lat", lat, 32'd1);
        step();
        step();

        // Video strobe during write setup: VID follows CPU_WH with no idle gap
        n0 = vid_cnt;
        cpu_op(1'b1, 10'h200, 4'h9, 1, 10'h010, -1, '0, lat, vk);
        chk("ws_wr_lat", lat, 32'd3);
        chk("ws_vid_no_gap_cs", {31'b0, o_ram_cs_n}, 32'd0);
        chk("ws_vid_no_gap_a", {22'b0, o_ram_a}, 32'h010);
        vid_wait(n0, vk, lat);
        chk("ws_vid_lat", lat, 32'd3);
        chk("ws_vid_data", {28'b0, last_vid_data}, 32'h6);
        step();
        step();
        chk("no_overrun_yet", {31'b0, o_vid_overrun}, 32'd0);

        // Two strobes during one write: single fetch of the second address
        n0 = vid_cnt;
        cpu_op(1'b1, 10'h201, 4'hC, 1, 10'h3A5, 2, 10'h010, lat, vk);
        chk("ovr_wr_lat", lat, 32'd3);
        vid_wait(n0, vk, lat);
        chk("ovr_vid_lat", lat, 32'd2);
        chk("ovr_vid_data", {28'b0, last_vid_data}, 32'h6);
        step();
        step();
        step();
        chk("ovr_vid_count", vid_cnt - n0, 32'd1);
        chk("ovr_flag", {31'b0, o_vid_overrun}, {31'b0, EXP_OVR});

        // Asynchronous reset in the middle of a write pulse
        cur_we = 1'b1;
        cur_addr = 10'h155;
        cur_wdata = 4'h3;
        i_cpu_we = 1'b1;
        i_cpu_addr = 10'h155;
        i_cpu_wdata = 4'h3;
        i_cpu_req = 1'b1;
        step();
        step();
        chk("in_wp_we_n", {31'b0, o_ram_we_n}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cs_n", {31'b0, o_ram_cs_n}, 32'd1);
        chk("arst_we_n", {31'b0, o_ram_we_n}, 32'd1);
        chk("arst_oe", {31'b0, o_ram_d_oe}, 32'd0);
        chk("arst_ack_valid", {30'b0, o_cpu_ack, o_vid_valid}, 32'd0);
        chk("arst_overrun", {31'b0, o_vid_overrun}, 32'd0);
        i_cpu_req = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        cpu_op(1'b0, 10'h010, 4'h0, -1, '0, -1, '0, lat, vk);
        chk("post_rst_rd_lat", lat, 32'd1);
        chk("post_rst_rd_data", {28'b0, o_cpu_rdata}, 32'h6);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Two-port arbiter and timing sequencer that sits directly upstream of a bank of 1024 x 4 static RAMs. It multiplexes CPU read/write cycles and video-scan read fetches onto one SRAM bus, driving chip select, write enable, address and write data. It captures SRAM read data into per-port registers. Video fetches have priority, and CPU write pulses are shaped so the RAM's data pins never contend with the write-data drivers.

## Interface
- AW, 10, SRAM address width
- DW, 4, SRAM data width
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request, level; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high
- cpu_addr  in  AW  CPU address; stable while cpu_req high
- cpu_wdata  in  DW  CPU write data; stable while cpu_req high
- cpu_rdata  out  DW  CPU read data, valid while cpu_ack high
- cpu_ack  out  1  one-cycle completion pulse
- vid_req  in  1  one-cycle video fetch strobe
- vid_addr  in  AW  video address, sampled with vid_req
- vid_data  out  DW  fetched video data, valid while vid_valid high
- vid_valid  out  1  one-cycle data-valid pulse
- vid_overrun  out  1  sticky overrun flag (see Configuration)
- ram_a  out  AW  SRAM address
- ram_cs_n  out  1  SRAM chip select, active low
- ram_we_n  out  1  SRAM write enable, active low
- ram_d_out  out  DW  write data toward SRAM
- ram_d_oe  out  1  write-data driver enable; the top level builds the tristate
- ram_d_in  in  DW  SRAM data pins as read back

## Operation
- States: IDLE, VID, CPU_RD, CPU_WS (write setup), CPU_WP (write pulse), CPU_WH (write hold).
- Pin values by state; all outputs are registered:
  - IDLE: cs_n=1, we_n=1, oe=0.
  - VID and CPU_RD: cs_n=0, we_n=1, oe=0.
  - CPU_WS and CPU_WH: cs_n=1, we_n=1, oe=1.
  - CPU_WP: cs_n=0, we_n=0, oe=1.
- ram_a and ram_d_out are latched on entry to a state and held constant through all states of that access.
- Video pending flag vid_pend:
  - Set by vid_req when the request cannot enter VID on the same edge; vid_addr is latched at that moment.
  - Cleared on entry to VID.
- Decision points are IDLE and VID. Priority at a decision point: video (vid_req or vid_pend) first, then cpu_req.
- cpu_req is ignored in any cycle where cpu_ack is high. A requester must drop cpu_req in its ack cycle, or a new access begins.
- From CPU_RD and CPU_WH the next state is VID if video is pending, else IDLE. The CPU is never re-granted without an intervening decision point.
- CPU_WS → CPU_WP → CPU_WH is non-preemptible.
- VID always lasts one cycle. On the exit edge ram_d_in is registered into vid_data and vid_valid pulses.
- CPU_RD lasts one cycle. On the exit edge ram_d_in is registered into cpu_rdata and cpu_ack pulses.
- CPU_WH exit edge pulses cpu_ack; cpu_rdata is left unchanged.
- Reset (asynchronous, any state): state=IDLE; cs_n=1, we_n=1, oe=0; ram_a=0, ram_d_out=0; cpu_rdata=0, vid_data=0; cpu_ack=0, vid_valid=0, vid_pend=0, vid_overrun=0. A write interrupted in CPU_WP is aborted; the RAM content at that address is undefined.

## Timing
- Latencies are counted from the edge k at which the request is sampled in IDLE. Each output is high for the cycle following the edge shown.
  - Video read: vid_valid after edge k+1.
  - CPU read: cpu_ack after edge k+1.
  - CPU write: cpu_ack after edge k+3.
- Worst-case video latency is a vid_req arriving in CPU_WS: VID is entered after CPU_WH with no idle gap, and vid_valid follows after edge k+3.
- Invariant: ram_d_oe=1 never coincides with ram_cs_n=0 and ram_we_n=1.
- Invariant: ram_a is constant whenever ram_we_n=0.

## Configuration
- Macro SRAM_ARB_OVERRUN_EN.
- Defined: vid_overrun goes high when vid_req arrives while vid_pend is already set. The new address overwrites the pending one. The flag is sticky until reset.
- Undefined: vid_overrun is tied 0; the overwrite behaviour is unchanged.

## Structure
- Shared package sram_arb_pkg holds:
  - the AW/DW defaults;
  - the arb_state_t enum (IDLE, VID, CPU_RD, CPU_WS, CPU_WP, CPU_WH).
- Single module, no sub-module. The per-state pin decode stays a case statement inside the state register block.

## Test plan
- Reset mid-CPU_WP: assert rst_n=0 → ram_cs_n=1, ram_we_n=1, ram_d_oe=0, cpu_ack=0, vid_valid=0 immediately, without waiting for a clock edge.
- CPU write 0xB to 0x3A5, then read 0x3A5 → cpu_ack at k+3 for the write and k+1 for the read; cpu_rdata=0xB; the we_n low pulse is exactly one cycle.
- Preload 0x010=0x6, then vid_req with vid_addr=0x010 in IDLE → vid_valid after edge k+1 with vid_data=0x6.
- vid_req and a CPU read request in the same cycle → VID first; CPU_RD next, and cpu_ack after edge k+2.
- vid_req during CPU_WS → CPU_WP and CPU_WH complete, then VID with no idle cycle; the contention invariant holds throughout.
- Two vid_req strobes during a CPU write → vid_overrun=1 with the macro defined and 0 without it; exactly one vid_valid, carrying the second address's data.
